// File: rtl/head_sram_wr_ctrl.sv
// head_sram_wr_ctrl: write-side packer for the head SRAM.
// Collects the per-element result stream of the head datapath, packs
// MAC_MULT_NUM elements per SRAM word (lane 0 in the LSBs) and drives the
// head SRAM write port. It pulses finish once the element count for the
// current layer phase has been written.
// Optional build macro HEAD_SRAM_WR_CHK_EN enables the sticky protocol
// error flag err. Without it, err is tied low.

package head_sram_wr_pkg;

  typedef enum logic [3:0] {
    IDLE_STATE   = 4'd0,
    Q_GEN_STATE  = 4'd1,
    K_GEN_STATE  = 4'd2,
    V_GEN_STATE  = 4'd3,
    ATT_QK_STATE = 4'd4,
    ATT_PV_STATE = 4'd5,
    PROJ_STATE   = 4'd6,
    FFN0_STATE   = 4'd7,
    FFN1_STATE   = 4'd8
  } CONTROL_STATE;

  typedef struct packed {
    logic [15:0] max_context_length;
    logic [7:0]  qkv_weight_cols_per_core;
  } MODEL_CONFIG;

  typedef struct packed {
    logic        user_kv_cache_not_full;
    logic [15:0] user_token_cnt;
  } USER_CONFIG;

endpackage

module head_sram_wr_ctrl
  import head_sram_wr_pkg::*;
#(
  parameter int MAC_MULT_NUM    = 16,
  parameter int HEAD_SRAM_DEPTH = 64,
  parameter int HEAD_CORE_NUM   = 8,
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = $clog2(MAC_MULT_NUM) + $clog2(HEAD_SRAM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  CONTROL_STATE                   control_state,
  input  logic                           control_state_update,
  input  logic                           model_cfg_vld,
  input  MODEL_CONFIG                    model_cfg,
  input  logic                           usr_cfg_vld,
  input  USER_CONFIG                     usr_cfg,
  input  logic                           start,
  input  logic                           in_vld,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_rdy,
  output logic                           head_sram_wen,
  output logic [ADDR_W-1:0]              head_sram_waddr,
  output logic [MAC_MULT_NUM*DATA_W-1:0] head_sram_wdata,
  output logic                           finish,
  output logic                           err
);

  localparam int LANE_W = $clog2(MAC_MULT_NUM);
  // One extra bit so element and word counters cannot wrap at full depth.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WORD_W = MAC_MULT_NUM * DATA_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q;
  CONTROL_STATE       control_state_reg;
  MODEL_CONFIG        model_cfg_reg;
  USER_CONFIG         usr_cfg_reg;
  logic               start_reg;
  logic [CNT_W-1:0]   n_q;
  logic [LANE_W-1:0]  lane_cnt;
  logic [CNT_W-1:0]   elem_cnt;
  logic [CNT_W-1:0]   word_cnt;
  logic [WORD_W-1:0]  pack_buf;

  logic [CNT_W-1:0]   hd;
  logic [CNT_W-1:0]   n_target;
  logic [WORD_W-1:0]  buf_next;
  logic               accept;
  logic               last_elem;
  logic               emit;
  logic               word_blocked;

  assign accept    = (state_q == BUSY) && in_vld && in_rdy;
  assign last_elem = (elem_cnt == n_q - CNT_W'(1));
  assign emit      = (lane_cnt == LANE_W'(MAC_MULT_NUM - 1)) || last_elem;

  // Element target for the phase held in the registered control state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hd       = CNT_W'(32'(model_cfg_reg.qkv_weight_cols_per_core) * HEAD_CORE_NUM);
    n_target = '0;
    case (control_state_reg)
      Q_GEN_STATE, K_GEN_STATE, V_GEN_STATE, ATT_PV_STATE, PROJ_STATE:
        n_target = hd;
      ATT_QK_STATE:
        n_target = usr_cfg_reg.user_kv_cache_not_full
                 ? CNT_W'(usr_cfg_reg.user_token_cnt) + CNT_W'(1)
                 : CNT_W'(model_cfg_reg.max_context_length);
      FFN0_STATE:
        n_target = CNT_W'(32'(model_cfg_reg.qkv_weight_cols_per_core) * HEAD_CORE_NUM * 4);
      default:
        n_target = '0;
    endcase
  end

  // Pack buffer with the incoming element dropped into the current lane.
  always_comb begin
    buf_next = pack_buf;
    buf_next[lane_cnt*DATA_W +: DATA_W] = in_data;
  end

`ifdef HEAD_SRAM_WR_CHK_EN
  localparam int WORD_LIMIT = HEAD_SRAM_DEPTH * MAC_MULT_NUM;
  assign word_blocked = (word_cnt == CNT_W'(WORD_LIMIT));

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((in_vld && state_q != BUSY) ||
                 (start_reg && state_q == BUSY) ||
                 word_blocked) begin
      err <= 1'b1;
    end
  end
`else
  assign word_blocked = 1'b0;
  assign err          = 1'b0;
`endif

  // Config capture, job FSM, lane packing and write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the pack buffer is plain flops, not a RAM, so clearing it on reset costs nothing and keeps wdata defined.
      state_q           <= IDLE;
      control_state_reg <= IDLE_STATE;
      model_cfg_reg     <= '0;
      usr_cfg_reg       <= '0;
      start_reg         <= 1'b0;
      n_q               <= '0;
      lane_cnt          <= '0;
      elem_cnt          <= '0;
      word_cnt          <= '0;
      pack_buf          <= '0;
      in_rdy            <= 1'b0;
      head_sram_wen     <= 1'b0;
      head_sram_waddr   <= '0;
      head_sram_wdata   <= '0;
      finish            <= 1'b0;
    end else begin
      head_sram_wen <= 1'b0;
      finish        <= 1'b0;
      start_reg     <= start;
      if (control_state_update) control_state_reg <= control_state;
      if (model_cfg_vld)        model_cfg_reg     <= model_cfg;
      if (usr_cfg_vld)          usr_cfg_reg       <= usr_cfg;

      if (start_reg) begin
        // A start in any state launches a fresh job and drops any partial word.
        n_q      <= n_target;
        lane_cnt <= '0;
        elem_cnt <= '0;
        word_cnt <= '0;
        pack_buf <= '0;
        if (n_target != '0) begin
          state_q <= BUSY;
          in_rdy  <= 1'b1;
        end else begin
          state_q <= DONE;
          in_rdy  <= 1'b0;
        end
      end else begin
        case (state_q)
          BUSY: begin
            if (accept) begin
              elem_cnt <= elem_cnt + CNT_W'(1);
              if (emit) begin
                if (!word_blocked) begin
                  head_sram_wen   <= 1'b1;
                  head_sram_waddr <= word_cnt[ADDR_W-1:0];
                  head_sram_wdata <= buf_next;
                end
                lane_cnt <= '0;
                word_cnt <= word_cnt + CNT_W'(1);
                pack_buf <= '0;
                if (last_elem) begin
                  state_q <= DONE;
                  in_rdy  <= 1'b0;
                end
              end else begin
                lane_cnt <= lane_cnt + LANE_W'(1);
                pack_buf <= buf_next;
              end
            end
          end
          DONE: begin
            finish  <= 1'b1;
            state_q <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_head_sram_wr_ctrl.sv
// Directed testbench for head_sram_wr_ctrl. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge. A monitor records every
// write and finish pulse together with its cycle number.
module tb_head_sram_wr_ctrl;
  import head_sram_wr_pkg::*;

  localparam int MAC_MULT_NUM    = 16;
  localparam int HEAD_SRAM_DEPTH = 64;
  localparam int HEAD_CORE_NUM   = 8;
  localparam int DATA_W          = 8;
  localparam int ADDR_W          = $clog2(MAC_MULT_NUM) + $clog2(HEAD_SRAM_DEPTH);
  localparam int WORD_W          = MAC_MULT_NUM * DATA_W;
`ifdef HEAD_SRAM_WR_CHK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  CONTROL_STATE        control_state;
  logic                control_state_update;
  logic                model_cfg_vld;
  MODEL_CONFIG         model_cfg;
  logic                usr_cfg_vld;
  USER_CONFIG          usr_cfg;
  logic                start;
  logic                in_vld;
  logic [DATA_W-1:0]   in_data;
  logic                in_rdy;
  logic                head_sram_wen;
  logic [ADDR_W-1:0]   head_sram_waddr;
  logic [WORD_W-1:0]   head_sram_wdata;
  logic                finish;
  logic                err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0] mon_addr[$];
  logic [WORD_W-1:0] mon_data[$];
  int                mon_cyc[$];
  int                fin_cnt = 0;
  int                fin_cyc = -1;

  head_sram_wr_ctrl #(
    .MAC_MULT_NUM   (MAC_MULT_NUM),
    .HEAD_SRAM_DEPTH(HEAD_SRAM_DEPTH),
    .HEAD_CORE_NUM  (HEAD_CORE_NUM),
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .control_state       (control_state),
    .control_state_update(control_state_update),
    .model_cfg_vld       (model_cfg_vld),
    .model_cfg           (model_cfg),
    .usr_cfg_vld         (usr_cfg_vld),
    .usr_cfg             (usr_cfg),
    .start               (start),
    .in_vld              (in_vld),
    .in_data             (in_data),
    .in_rdy              (in_rdy),
    .head_sram_wen       (head_sram_wen),
    .head_sram_waddr     (head_sram_waddr),
    .head_sram_wdata     (head_sram_wdata),
    .finish              (finish),
    .err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write / finish monitor.
  always @(negedge clk) begin
    if (head_sram_wen) begin
      mon_addr.push_back(head_sram_waddr);
      mon_data.push_back(head_sram_wdata);
      mon_cyc.push_back(cyc);
    end
    if (finish) begin
      fin_cnt = fin_cnt + 1;
      fin_cyc = cyc;
    end
  end

  // Expected word: cnt consecutive element values from first, remaining lanes 0.
  function automatic logic [WORD_W-1:0] exp_word(int first, int cnt);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int l = 0; l < MAC_MULT_NUM; l++)
      if (l < cnt) w[l*DATA_W +: DATA_W] = DATA_W'(first + l);
    return w;
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    fin_cnt = 0;
    fin_cyc = -1;
  endtask

  task automatic configure(CONTROL_STATE st, int cols, int ctx, int tok, logic nf);
    control_state                      = st;
    model_cfg.qkv_weight_cols_per_core = 8'(cols);
    model_cfg.max_context_length       = 16'(ctx);
    usr_cfg.user_token_cnt             = 16'(tok);
    usr_cfg.user_kv_cache_not_full     = nf;
    control_state_update = 1'b1;
    model_cfg_vld        = 1'b1;
    usr_cfg_vld          = 1'b1;
    @(negedge clk);
    control_state_update = 1'b0;
    model_cfg_vld        = 1'b0;
    usr_cfg_vld          = 1'b0;
  endtask

  task automatic pulse_start(output int start_cyc);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for in_rdy, then presents n elements base, base+1, ...
  task automatic stream(int n, int base, logic toggle, output int last_cyc);
    int guard;
    guard    = 0;
    last_cyc = -1;
    while (!in_rdy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!in_rdy) begin
      errors++;
      $display("FAIL stream_rdy_timeout: in_rdy=%0b expected 1", in_rdy);
    end
    for (int i = 0; i < n; i++) begin
      in_vld   = 1'b1;
      in_data  = DATA_W'(base + i);
      last_cyc = cyc;
      @(negedge clk);
      if (toggle) begin
        in_vld = 1'b0;
        @(negedge clk);
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({head_sram_wen, finish, in_rdy, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: wen/finish/rdy/err=%b expected 0000",
               {head_sram_wen, finish, in_rdy, err});
    end
    checks++;
    if (head_sram_waddr !== '0 || head_sram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: waddr=%0d wdata=%h expected 0", head_sram_waddr, head_sram_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Q_GEN, HD=64: four full words, elements 0..63.
  task automatic test_q_gen();
    int sc, last, lw;
    clear_mon();
    configure(Q_GEN_STATE, 8, 128, 0, 1'b0);
    pulse_start(sc);
    stream(64, 0, 1'b0, last);
    repeat (6) @(negedge clk);
    checks++;
    if (mon_addr.size() != 4) begin
      errors++;
      $display("FAIL q_gen_wen_count: got %0d expected 4", mon_addr.size());
    end
    for (int w = 0; w < 4 && w < mon_addr.size(); w++) begin
      checks++;
      if (mon_addr[w] !== ADDR_W'(w)) begin
        errors++;
        $display("FAIL q_gen_addr[%0d]: got %0d expected %0d", w, mon_addr[w], w);
      end
      checks++;
      if (mon_data[w] !== exp_word(16 * w, 16)) begin
        errors++;
        $display("FAIL q_gen_data[%0d]: got %h expected %h", w, mon_data[w], exp_word(16 * w, 16));
      end
    end
    lw = (mon_cyc.size() > 0) ? mon_cyc[mon_cyc.size()-1] : -1;
    checks++;
    if (lw != last + 1) begin
      errors++;
      $display("FAIL q_gen_wen_latency: last wen cycle %0d expected %0d", lw, last + 1);
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != last + 2) begin
      errors++;
      $display("FAIL q_gen_finish: count %0d at cycle %0d expected 1 at %0d", fin_cnt, fin_cyc, last + 2);
    end
  endtask

  // ATT_QK: kv not full (N=token_cnt+1=21) and kv full (N=max_context_length=18).
  task automatic test_att_qk();
    int sc, last;
    int tail[2];
    tail[0] = 5;
    tail[1] = 2;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      if (k == 0) configure(ATT_QK_STATE, 8, 18, 20, 1'b1);
      else        configure(ATT_QK_STATE, 8, 18, 20, 1'b0);
      pulse_start(sc);
      stream(16 + tail[k], 0, 1'b0, last);
      repeat (6) @(negedge clk);
      checks++;
      if (mon_addr.size() != 2) begin
        errors++;
        $display("FAIL att_qk%0d_wen_count: got %0d expected 2", k, mon_addr.size());
      end else begin
        checks++;
        if (mon_addr[0] !== ADDR_W'(0) || mon_addr[1] !== ADDR_W'(1)) begin
          errors++;
          $display("FAIL att_qk%0d_addr: got %0d,%0d expected 0,1", k, mon_addr[0], mon_addr[1]);
        end
        checks++;
        if (mon_data[0] !== exp_word(0, 16)) begin
          errors++;
          $display("FAIL att_qk%0d_word0: got %h expected %h", k, mon_data[0], exp_word(0, 16));
        end
        checks++;
        if (mon_data[1] !== exp_word(16, tail[k])) begin
          errors++;
          $display("FAIL att_qk%0d_word1: got %h expected %h", k, mon_data[1], exp_word(16, tail[k]));
        end
      end
      checks++;
      if (fin_cnt != 1 || fin_cyc != last + 2) begin
        errors++;
        $display("FAIL att_qk%0d_finish: count %0d at cycle %0d expected 1 at %0d", k, fin_cnt, fin_cyc, last + 2);
      end
    end
  endtask

  // FFN0, HD=64 (N=256), in_vld at 50%, control_state changed mid-job.
  task automatic test_ffn0_toggle();
    int sc, last;
    int bad_addr, bad_data;
    clear_mon();
    configure(FFN0_STATE, 8, 128, 0, 1'b0);
    pulse_start(sc);
    @(negedge clk);
    control_state        = FFN1_STATE;
    control_state_update = 1'b1;
    @(negedge clk);
    control_state_update = 1'b0;
    stream(256, 0, 1'b1, last);
    repeat (6) @(negedge clk);
    checks++;
    if (mon_addr.size() != 16) begin
      errors++;
      $display("FAIL ffn0_wen_count: got %0d expected 16", mon_addr.size());
    end
    bad_addr = 0;
    bad_data = 0;
    for (int w = 0; w < mon_addr.size(); w++) begin
      if (mon_addr[w] !== ADDR_W'(w)) bad_addr++;
      if (mon_data[w] !== exp_word(16 * w, 16)) bad_data++;
    end
    checks++;
    if (bad_addr != 0) begin
      errors++;
      $display("FAIL ffn0_addr: %0d words at wrong address, expected 0", bad_addr);
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL ffn0_data: %0d words with wrong lanes, expected 0", bad_data);
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != last + 2) begin
      errors++;
      $display("FAIL ffn0_finish: count %0d at cycle %0d expected 1 at %0d", fin_cnt, fin_cyc, last + 2);
    end
  endtask

  // FFN1: N=0, no writes. start_reg is seen in cycle sc+1, DONE in sc+2, finish in sc+3.
  task automatic test_ffn1();
    int sc;
    clear_mon();
    configure(FFN1_STATE, 8, 128, 0, 1'b0);
    pulse_start(sc);
    repeat (6) @(negedge clk);
    checks++;
    if (mon_addr.size() != 0) begin
      errors++;
      $display("FAIL ffn1_wen_count: got %0d expected 0", mon_addr.size());
    end
    checks++;
    if (fin_cnt != 1 || fin_cyc != sc + 3) begin
      errors++;
      $display("FAIL ffn1_finish: count %0d at cycle %0d expected 1 at %0d", fin_cnt, fin_cyc, sc + 3);
    end
  endtask

  // ATT_PV: abort after 10 elements, then restart and send a full job.
  task automatic test_restart();
    int sc, last;
    int bad;
    clear_mon();
    configure(ATT_PV_STATE, 8, 128, 0, 1'b0);
    pulse_start(sc);
    stream(10, 200, 1'b0, last);
    pulse_start(sc);
    repeat (2) @(negedge clk);
    stream(64, 0, 1'b0, last);
    repeat (6) @(negedge clk);
    checks++;
    if (mon_addr.size() != 4) begin
      errors++;
      $display("FAIL restart_wen_count: got %0d expected 4", mon_addr.size());
    end
    bad = 0;
    for (int w = 0; w < mon_addr.size(); w++)
      if (mon_addr[w] !== ADDR_W'(w) || mon_data[w] !== exp_word(16 * w, 16)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_words: %0d bad words, expected 0", bad);
    end
    checks++;
    if (fin_cnt != 1) begin
      errors++;
      $display("FAIL restart_finish_count: got %0d expected 1", fin_cnt);
    end
    checks++;
    if (err !== CHK_EN) begin
      errors++;
      $display("FAIL restart_err: got %b expected %b", err, CHK_EN);
    end
  endtask

  // One-cycle reset in the middle of a Q_GEN job.
  task automatic test_reset_mid_job();
    int sc, last;
    int rdy_seen;
    clear_mon();
    configure(Q_GEN_STATE, 8, 128, 0, 1'b0);
    pulse_start(sc);
    stream(5, 0, 1'b0, last);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({head_sram_wen, finish, in_rdy, err} !== 4'b0000 ||
        head_sram_waddr !== '0 || head_sram_wdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: wen/fin/rdy/err=%b waddr=%0d wdata=%h expected all 0",
               {head_sram_wen, finish, in_rdy, err}, head_sram_waddr, head_sram_wdata);
    end
    rdy_seen = 0;
    in_vld   = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_rdy) rdy_seen++;
    end
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rdy_seen != 0) begin
      errors++;
      $display("FAIL mid_reset_rdy: in_rdy high %0d cycles, expected 0", rdy_seen);
    end
    checks++;
    if (mon_addr.size() != 0 || fin_cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_activity: %0d writes %0d finishes, expected 0 and 0", mon_addr.size(), fin_cnt);
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    control_state        = IDLE_STATE;
    control_state_update = 1'b0;
    model_cfg_vld        = 1'b0;
    model_cfg            = '0;
    usr_cfg_vld          = 1'b0;
    usr_cfg              = '0;
    start                = 1'b0;
    in_vld               = 1'b0;
    in_data              = '0;
    @(negedge clk);
    test_reset();
    test_q_gen();
    test_att_qk();
    test_ffn0_toggle();
    test_ffn1();
    test_restart();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
